parser_action_engine: RTL and testbench
=======================================

Name: parser_action_engine

Overview:
- Multi-step header-walking engine for the packet parser. Takes one header per packet and runs up to MAX_STEPS configured actions, one action per cycle.
- Each action advances a running bit offset, either by a direct constant or by a length field read from the header, then extracts a KEY_W-bit lookup key at the new offset.
- Keys stream out over a valid/ready interface to the match stage. This replaces the single-shot combinational action pair with a sequenced, table-driven, back-pressured engine that detects errors.

Parameters:
- HDR_W, 2048, header width in bits
- OFF_W, 12, offset and field width in bits
- KEY_W, 144, extracted key width
- MAX_STEPS, 4, action table depth and maximum actions per packet
- STEP_W, 2, index width; equals clog2(MAX_STEPS)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  action table write strobe
- cfg_addr  in  STEP_W  table entry index
- cfg_data  in  ACT_W  packed action (see Decomposition)
- in_valid  in  1  header available
- in_ready  out  1  engine idle and able to accept a header
- in_header  in  HDR_W  message header; bit position 0 is in_header[HDR_W-1]
- in_base  in  OFF_W  starting offset
- in_ctrl  in  MAX_STEPS  per-step sel inversion mask
- key_valid  out  1  key present
- key_ready  in  1  downstream accepts key
- key_data  out  KEY_W  extracted key
- key_step  out  STEP_W  step index that produced the key
- key_last  out  1  final key of this packet
- key_err  out  1  offset overflow; key_data is zero
- offset_out  out  OFF_W  offset after the step

Behaviour:
- Reset values: in_ready=1. key_valid, key_data, key_step, key_last, key_err and offset_out all 0. FSM=IDLE. The action table is cleared to all-zero, so each entry means direct mode with zero advance, and last=0.
- FSM states: IDLE, RUN, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready, latch the header, base and ctrl mask; set step=0, off=in_base; go to RUN.
- RUN: one action per cycle. Compute as follows:
  - sel_eff = act.sel XOR ctrl[step]
  - field = the OFF_W bits starting at position off+act.pos, MSB-first
  - masked = field with only the low act.vnum bits kept; vnum≥OFF_W keeps all bits, vnum=0 gives 0
  - scaled = masked shifted left by the kind amount: kind 00 by 0, 01 by 3, 10 by 5, 11 by 6; then add act.comp
  - adv = sel_eff ? act.dir : scaled
  - nxt = off+adv
- Arithmetic: nxt is computed at OFF_W+1 bits. Overflow occurs when the carry is set, or nxt+KEY_W>HDR_W, or a field read exceeds HDR_W.
- Register the output on the next edge: key_valid=1, key_data=header[nxt..nxt+KEY_W-1] (MSB-first), key_step=step, offset_out=nxt[OFF_W-1:0], key_err=overflow, and key_last = act.last OR step==MAX_STEPS-1 OR overflow. Set off=nxt and go to HOLD.
- HOLD: hold all key outputs stable while key_ready=0. On key_ready:
  - if key_last: drop key_valid and go to IDLE; in_ready rises in the same cycle
  - otherwise: step+1, drop key_valid, go to RUN
- Latency: first key is visible 2 cycles after input acceptance. Throughput is one key per 2 cycles with no back-pressure.
- cfg_we is honoured in any state. A write to the entry being computed in the current RUN cycle takes effect only on the next packet; RUN reads a snapshot of that entry.
- On overflow, processing of the packet stops after the erroring key is emitted.
- Reset mid-packet: all state clears asynchronously, the packet is dropped, and no partial key remains on the outputs.

Decomposition:
- Package parser_pkg holds:
  - the action_t struct: sel, last, kind[1:0], vnum[3:0], pos[OFF_W-1:0], dir[OFF_W-1:0], comp[OFF_W-1:0]
  - ACT_W
  - the kind shift constants
  - the FSM state enum
- One sub-module, parser_offset_calc: purely combinational. It computes nxt and the overflow flag from header, off, action and ctrl bit. It is shared with any future parallel variant.
- Key extraction is an indexed part-select in the top module.

Test Plan:
- Direct chain:
  - Stimulus: entries 0..1 = dir 112, then dir 160 with last; base 0; ctrl 0.
  - Response: keys at offsets 112 and 272; key_step 0 then 1; key_last only on the second key; in_ready returns to 1.
- Field-driven:
  - Stimulus: header bits [0..11]=0x005, entry 0 = sel 0, pos 0, vnum 4, kind 01, comp 8.
  - Response: offset_out=48 (5<<3 plus 8); key_data equals header bits 48..191.
- Ctrl inversion:
  - Stimulus: same setup with ctrl[0]=1 and dir 20.
  - Response: offset_out=20.
- Overflow:
  - Stimulus: base 1950, dir 0.
  - Response: key_err=1, key_last=1, key_data=0; no further keys are emitted.
- Back-pressure:
  - Stimulus: hold key_ready=0 for 5 cycles during step 0.
  - Response: outputs stay stable; step 1 is not computed; no keys are lost or duplicated.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 while in HOLD.
  - Response: key_valid=0 immediately and in_ready=1 after release; the next packet starts at step 0.

Source files
------------

// File: rtl/parser_pkg.sv
// Shared types and constants for the packet parser action engine.
// Action entries, kind shift amounts and engine FSM states.
package parser_pkg;

  localparam int HDR_W     = 2048;
  localparam int OFF_W     = 12;
  localparam int KEY_W     = 144;
  localparam int MAX_STEPS = 4;
  localparam int STEP_W    = 2;
  localparam int HIDX_W    = $clog2(HDR_W);

  localparam logic [2:0] SH_K0 = 3'd0;
  localparam logic [2:0] SH_K1 = 3'd3;
  localparam logic [2:0] SH_K2 = 3'd5;
  localparam logic [2:0] SH_K3 = 3'd6;

  typedef struct packed {
    logic             sel;
    logic             last;
    logic [1:0]       kind;
    logic [3:0]       vnum;
    logic [OFF_W-1:0] pos;
    logic [OFF_W-1:0] dir;
    logic [OFF_W-1:0] comp;
  } action_t;

  localparam int ACT_W = $bits(action_t);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  function automatic logic [2:0] kind_shift(
    input logic [1:0] kind
  );
    logic [2:0] sh;
    unique case (kind)
      2'b00:   sh = SH_K0;
      2'b01:   sh = SH_K1;
      2'b10:   sh = SH_K2;
      default: sh = SH_K3;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/parser_offset_calc.sv
// Combinational offset advance for one action step.
// Yields the next offset and an overflow flag.
module parser_offset_calc
  import parser_pkg::*;
(
  input  logic [HDR_W-1:0] header,
  input  logic [OFF_W-1:0] off,
  input  action_t          act,
  input  logic             ctrl_bit,
  output logic [OFF_W:0]   nxt,
  output logic             ovf
);

  localparam int WW = OFF_W + 3;

  logic              sel_eff;
  logic [OFF_W:0]    fpos;
  logic              fld_in;
  logic [HIDX_W-1:0] fidx;
  logic [OFF_W-1:0]  field;
  logic [OFF_W-1:0]  mask;
  logic [OFF_W-1:0]  scaled;
  logic [OFF_W-1:0]  adv;
  logic              fld_ovf;
  logic              key_ovf;

  always_comb begin
    sel_eff = act.sel ^ ctrl_bit;
    fpos    = {1'b0, off} + {1'b0, act.pos};
    fld_in  = ({2'b0, fpos} + WW'(OFF_W)) <= WW'(HDR_W);
    fidx    = fld_in ? HIDX_W'(HDR_W - 1 - int'(fpos))
                     : HIDX_W'(HDR_W - 1);
    field   = fld_in ? header[fidx -: OFF_W] : '0;
    if (int'(act.vnum) >= OFF_W)
      mask = '1;
    else
      mask = OFF_W'((1 << act.vnum) - 1);
    scaled  = ((field & mask) << kind_shift(act.kind)) + act.comp;
    adv     = sel_eff ? act.dir : scaled;
    nxt     = {1'b0, off} + {1'b0, adv};
    // field only matters when it actually feeds the advance
    fld_ovf = !sel_eff && (act.vnum != 4'd0) && !fld_in;
    key_ovf = ({2'b0, nxt} + WW'(KEY_W)) > WW'(HDR_W);
    ovf     = nxt[OFF_W] | key_ovf | fld_ovf;
  end

endmodule

// File: rtl/parser_action_engine.sv
// Sequenced, table-driven header walker emitting one key per step
// over a valid/ready stream to the match stage.
module parser_action_engine
  import parser_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [STEP_W-1:0]    cfg_addr,
  input  logic [ACT_W-1:0]     cfg_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HDR_W-1:0]     in_header,
  input  logic [OFF_W-1:0]     in_base,
  input  logic [MAX_STEPS-1:0] in_ctrl,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [KEY_W-1:0]     key_data,
  output logic [STEP_W-1:0]    key_step,
  output logic                 key_last,
  output logic                 key_err,
  output logic [OFF_W-1:0]     offset_out
);

  state_e               state;
  action_t              tbl [MAX_STEPS];
  logic [HDR_W-1:0]     hdr;
  logic [OFF_W-1:0]     off;
  logic [MAX_STEPS-1:0] ctrl;
  logic [STEP_W-1:0]    step;

  action_t              act;
  logic [OFF_W:0]       nxt;
  logic                 ovf;
  logic [HIDX_W-1:0]    kidx;
  logic [KEY_W-1:0]     key_w;
  logic                 last_w;

  assign act      = tbl[step];
  assign in_ready = (state == S_IDLE);

  parser_offset_calc u_calc (
    .header   (hdr),
    .off      (off),
    .act      (act),
    .ctrl_bit (ctrl[step]),
    .nxt      (nxt),
    .ovf      (ovf)
  );

  always_comb begin
    kidx   = ovf ? HIDX_W'(KEY_W - 1)
                 : HIDX_W'(HDR_W - 1 - int'(nxt));
    key_w  = ovf ? '0 : hdr[kidx -: KEY_W];
    last_w = act.last | ovf
           | (step == STEP_W'(MAX_STEPS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_STEPS; i++)
        tbl[i] <= '0;
    end else if (cfg_we) begin
      tbl[cfg_addr] <= action_t'(cfg_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hdr        <= '0;
      off        <= '0;
      ctrl       <= '0;
      step       <= '0;
      key_valid  <= 1'b0;
      key_data   <= '0;
      key_step   <= '0;
      key_last   <= 1'b0;
      key_err    <= 1'b0;
      offset_out <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (in_valid) begin
            hdr   <= in_header;
            off   <= in_base;
            ctrl  <= in_ctrl;
            step  <= '0;
            state <= S_RUN;
          end
        end
        (state == S_RUN): begin
          key_valid  <= 1'b1;
          key_data   <= key_w;
          key_step   <= step;
          key_last   <= last_w;
          key_err    <= ovf;
          offset_out <= nxt[OFF_W-1:0];
          off        <= nxt[OFF_W-1:0];
          state      <= S_HOLD;
        end
        (state == S_HOLD): begin
          if (key_ready) begin
            key_valid <= 1'b0;
            if (key_last) begin
              state <= S_IDLE;
            end else begin
              step  <= step + 1'b1;
              state <= S_RUN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parser_action_engine.sv
// Scoreboard bench for parser_action_engine: directed packets,
// monitor pops expected keys on every presented key.
module tb_parser_action_engine;
  import parser_pkg::*;

  typedef struct {
    logic [KEY_W-1:0]  key;
    logic [STEP_W-1:0] step;
    logic              last;
    logic              err;
    logic [OFF_W-1:0]  off;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_we = 1'b0;
  logic [STEP_W-1:0]    cfg_addr = '0;
  logic [ACT_W-1:0]     cfg_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [HDR_W-1:0]     in_header = '0;
  logic [OFF_W-1:0]     in_base = '0;
  logic [MAX_STEPS-1:0] in_ctrl = '0;
  logic                 key_valid;
  logic                 key_ready = 1'b1;
  logic [KEY_W-1:0]     key_data;
  logic [STEP_W-1:0]    key_step;
  logic                 key_last;
  logic                 key_err;
  logic [OFF_W-1:0]     offset_out;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [HDR_W-1:0] h;

  parser_action_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_header  (in_header),
    .in_base    (in_base),
    .in_ctrl    (in_ctrl),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_data   (key_data),
    .key_step   (key_step),
    .key_last   (key_last),
    .key_err    (key_err),
    .offset_out (offset_out)
  );

  always #5 clk = ~clk;

  function automatic logic [KEY_W-1:0] hbits(
    input logic [HDR_W-1:0] hv,
    input int               pos
  );
    logic [KEY_W-1:0] k;
    for (int i = 0; i < KEY_W; i++)
      k[KEY_W-1-i] = hv[HDR_W-1-(pos+i)];
    return k;
  endfunction

  function automatic action_t mk(
    input logic sel, input logic last,
    input logic [1:0] kind, input logic [3:0] vnum,
    input int pos, input int dir, input int comp
  );
    action_t a;
    a.sel  = sel;
    a.last = last;
    a.kind = kind;
    a.vnum = vnum;
    a.pos  = OFF_W'(pos);
    a.dir  = OFF_W'(dir);
    a.comp = OFF_W'(comp);
    return a;
  endfunction

  task automatic expect_key(
    input logic [HDR_W-1:0] hv, input int off,
    input int step, input logic last, input logic err
  );
    exp_t e;
    e.key  = err ? '0 : hbits(hv, off);
    e.step = STEP_W'(step);
    e.last = last;
    e.err  = err;
    e.off  = OFF_W'(off);
    sb.push_back(e);
  endtask

  task automatic cfg(input int addr, input action_t a);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = STEP_W'(addr);
    cfg_data = a;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic send(
    input logic [HDR_W-1:0] hv, input int base,
    input logic [MAX_STEPS-1:0] c
  );
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    in_valid  = 1'b1;
    in_header = hv;
    in_base   = OFF_W'(base);
    in_ctrl   = c;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || !in_ready) begin
      failures++;
      $display("FAIL %s_drain pending=%0d in_ready=%0b required 0/1",
               name, sb.size(), in_ready);
    end
  endtask

  task automatic wait_kv(input string name);
    int n = 0;
    while (!key_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!key_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_wait key_valid=0 required=1", name);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_key step=%0d off=%0d required none",
                 key_step, offset_out);
      end else begin
        if (key_data !== sb[0].key || key_step !== sb[0].step ||
            key_last !== sb[0].last || key_err !== sb[0].err ||
            offset_out !== sb[0].off) begin
          failures++;
          $display("FAIL key got off=%0d step=%0d last=%0b err=%0b data=%h required off=%0d step=%0d last=%0b err=%0b data=%h",
                   offset_out, key_step, key_last, key_err, key_data,
                   sb[0].off, sb[0].step, sb[0].last, sb[0].err, sb[0].key);
        end
        if (key_ready)
          void'(sb.pop_front());
      end
    end
  end

  initial begin
    int cnt;
    for (int w = 0; w < HDR_W / 32; w++)
      h[w*32 +: 32] = $urandom;

    #12;
    checks++;
    if (in_ready !== 1'b1 || key_valid !== 1'b0 || key_data !== '0 ||
        key_step !== '0 || key_last !== 1'b0 || key_err !== 1'b0 ||
        offset_out !== '0) begin
      failures++;
      $display("FAIL reset_state rdy=%0b kv=%0b off=%0d required 1/0/0",
               in_ready, key_valid, offset_out);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // direct chain
    cfg(0, mk(1, 0, 2'b00, 0, 0, 112, 0));
    cfg(1, mk(1, 1, 2'b00, 0, 0, 160, 0));
    expect_key(h, 112, 0, 0, 0);
    expect_key(h, 272, 1, 1, 0);
    send(h, 0, 4'b0000);
    drain("direct");

    // field-driven: 5<<3 + 8 = 48, then direct 160
    h[HDR_W-1 -: OFF_W] = 12'h005;
    cfg(0, mk(0, 0, 2'b01, 4, 0, 0, 8));
    expect_key(h, 48, 0, 0, 0);
    expect_key(h, 208, 1, 1, 0);
    send(h, 0, 4'b0000);
    drain("field");

    // ctrl inversion turns the field action into dir 20
    cfg(0, mk(0, 0, 2'b01, 4, 0, 20, 8));
    expect_key(h, 20, 0, 0, 0);
    expect_key(h, 180, 1, 1, 0);
    send(h, 0, 4'b0001);
    drain("ctrl");

    // overflow: 1950 + 144 > 2048
    cfg(0, mk(1, 0, 2'b00, 0, 0, 0, 0));
    expect_key(h, 1950, 0, 1, 1);
    send(h, 1950, 4'b0000);
    drain("ovf");
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (key_valid) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      failures++;
      $display("FAIL ovf_extra_keys got=%0d required=0", cnt);
    end

    // back-pressure on step 0
    cfg(0, mk(1, 0, 2'b00, 0, 0, 112, 0));
    expect_key(h, 112, 0, 0, 0);
    expect_key(h, 272, 1, 1, 0);
    @(posedge clk);
    #1 key_ready = 1'b0;
    send(h, 0, 4'b0000);
    wait_kv("bp");
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 key_ready = 1'b1;
    drain("bp");

    // reset while holding a key
    @(posedge clk);
    #1 key_ready = 1'b0;
    expect_key(h, 112, 0, 0, 0);
    expect_key(h, 272, 1, 1, 0);
    send(h, 0, 4'b0000);
    wait_kv("rst");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (key_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid kv=%0b rdy=%0b required 0/1",
               key_valid, in_ready);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    key_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || key_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_release rdy=%0b kv=%0b required 1/0",
               in_ready, key_valid);
    end
    cfg(0, mk(1, 0, 2'b00, 0, 0, 112, 0));
    cfg(1, mk(1, 1, 2'b00, 0, 0, 160, 0));
    expect_key(h, 112, 0, 0, 0);
    expect_key(h, 272, 1, 1, 0);
    send(h, 0, 4'b0000);
    drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
